// File: rtl/soc_timer.sv
// soc_timer: memory-mapped compare timer with an optional 16-bit prescaler.
// Optional feature macro: TIMER_PRESCALER_EN
//   defined   -> PRESCALE register and pre_cnt divider; tick every PRESCALE+1 cycles
//   undefined -> no prescaler storage; tick every enabled cycle, PRESCALE reads 0
// Register map by addr_i[4:2]: 0 CTRL, 1 PRESCALE, 2 COMPARE, 3 COUNT, 4 STATUS.
// DATA_BUS_WIDTH must be at least 32; registers occupy the low 32 bits.
module soc_timer #(
  parameter int unsigned ADDR_BUS_WIDTH = 32,
  parameter int unsigned DATA_BUS_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_BUS_WIDTH-1:0] addr_i,
  input  logic [DATA_BUS_WIDTH-1:0] data_i,
  output logic [DATA_BUS_WIDTH-1:0] data_o,
  input  logic                      we_i,
  input  logic                      rd_i,
  output logic                      irq_o
);

  localparam int unsigned REG_W = 32;
  localparam int unsigned PRE_W = 16;
  localparam logic [DATA_BUS_WIDTH-1:0] ZERO_WORD = '0;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_COUNT    = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  localparam logic [REG_W-1:0] COMPARE_RST = 32'hFFFF_FFFF;

  logic [2:0]       off;
  logic             ctrl_en;
  logic             ctrl_periodic;
  logic             ctrl_ie;
  logic             status_match;
  logic [REG_W-1:0] compare_q;
  logic [REG_W-1:0] count_q;
  logic [REG_W-1:0] wdata;
  logic [PRE_W-1:0] prescale_rd;
  logic             wr_ctrl;
  logic             wr_compare;
  logic             wr_count;
  logic             wr_status;
  logic             tick;
  logic             hit;
  logic [REG_W-1:0] rdata;
  logic             unused_addr;

  assign off         = addr_i[4:2];
  assign wdata       = data_i[REG_W-1:0];
  assign unused_addr = ^{addr_i[ADDR_BUS_WIDTH-1:5], addr_i[1:0]};

  // Write-strobe decode; offsets 5-7 decode to nothing
  always_comb begin
    wr_ctrl    = 1'b0;
    wr_compare = 1'b0;
    wr_count   = 1'b0;
    wr_status  = 1'b0;
    if (we_i) begin
      case (off)
        OFF_CTRL:    wr_ctrl    = 1'b1;
        OFF_COMPARE: wr_compare = 1'b1;
        OFF_COUNT:   wr_count   = 1'b1;
        OFF_STATUS:  wr_status  = 1'b1;
        default:     ;
      endcase
    end
  end

`ifdef TIMER_PRESCALER_EN
  logic [PRE_W-1:0] prescale_q;
  logic [PRE_W-1:0] pre_cnt;
  logic             wr_pre;

  assign wr_pre      = we_i && (off == OFF_PRESCALE);
  assign prescale_rd = prescale_q;

  // Tick when the divider reaches the programmed terminal value
  always_comb begin
    tick = ctrl_en && (pre_cnt == prescale_q);
  end

  // PRESCALE register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
    end else if (wr_pre) begin
      prescale_q <= wdata[PRE_W-1:0];
    end
  end

  // Divider: restarts on CTRL/PRESCALE writes, parked at 0 while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (wr_pre || wr_ctrl || !ctrl_en || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end
`else
  assign prescale_rd = '0;

  // No divider: every enabled cycle is a tick
  always_comb begin
    tick = ctrl_en;
  end
`endif

  // A bus write to COUNT pre-empts the compare in the same cycle
  always_comb begin
    hit = tick && !wr_count && (count_q == compare_q);
  end

  // CTRL: bus write wins over the one-shot auto-disable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en       <= 1'b0;
      ctrl_periodic <= 1'b0;
      ctrl_ie       <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en       <= wdata[0];
      ctrl_periodic <= wdata[1];
      ctrl_ie       <= wdata[2];
    end else if (hit && !ctrl_periodic) begin
      ctrl_en <= 1'b0;
    end
  end

  // COMPARE register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_q <= COMPARE_RST;
    end else if (wr_compare) begin
      compare_q <= wdata;
    end
  end

  // COUNT: bus write, else advance/restart/hold on tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (wr_count) begin
      count_q <= wdata;
    end else if (tick) begin
      if (count_q == compare_q) begin
        if (ctrl_periodic) begin
          count_q <= '0;
        end
      end else begin
        count_q <= count_q + REG_W'(1);
      end
    end
  end

  // STATUS.match: set has priority over write-one-to-clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_match <= 1'b0;
    end else if (hit) begin
      status_match <= 1'b1;
    end else if (wr_status && wdata[0]) begin
      status_match <= 1'b0;
    end
  end

  // Read mux: side-effect free, zero when not reading or unmapped
  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:     rdata = {29'd0, ctrl_ie, ctrl_periodic, ctrl_en};
      OFF_PRESCALE: rdata = {16'd0, prescale_rd};
      OFF_COMPARE:  rdata = compare_q;
      OFF_COUNT:    rdata = count_q;
      OFF_STATUS:   rdata = {31'd0, status_match};
      default:      rdata = '0;
    endcase
  end

  // Bus read data
  always_comb begin
    data_o = ZERO_WORD;
    if (rd_i) begin
      data_o = DATA_BUS_WIDTH'(rdata);
    end
  end

  // Level interrupt
  always_comb begin
    irq_o = status_match && ctrl_ie;
  end

endmodule

// File: doc/soc_timer.md
SOC_TIMER -- requirements
Module: soc_timer

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 addr_i  input  ADDR_BUS_WIDTH  bus address; only addr_i[4:2] decoded; region select is done by the bus decoder.
REQ-005 data_i  input  DATA_BUS_WIDTH  write data.
REQ-006 data_o  output  DATA_BUS_WIDTH  read data; combinational from addr_i and register state.
REQ-007 we_i  input  1  write strobe (timer-region-qualified we from the bus decoder).
REQ-008 rd_i  input  1  read strobe (timer-region-qualified rd from the bus decoder).
REQ-009 irq_o  output  1  timer interrupt, level, = STATUS.match AND CTRL.ie.

Function
REQ-010 Register map by addr_i[4:2] SHALL be: 0 CTRL (bit0 en, bit1 periodic, bit2 ie), 1 PRESCALE[15:0], 2 COMPARE[31:0], 3 COUNT[31:0], 4 STATUS (bit0 match); unused bits read 0.
REQ-011 Writes SHALL take effect on the rising edge where we_i=1, zero wait states; offsets 5-7 ignored.
REQ-012 data_o SHALL present the addressed register whenever rd_i=1, ZERO_WORD when rd_i=0 or offset 5-7; reads have no side effects.
REQ-013 Prescale counter pre_cnt (16 bit) SHALL: when en=1, wrap to 0 and assert one-cycle tick if pre_cnt==PRESCALE, else increment; when en=0, hold at 0.
REQ-014 On tick with COUNT!=COMPARE, COUNT SHALL increment, wrapping 0xFFFF_FFFF -> 0.
REQ-015 On tick with COUNT==COMPARE, STATUS.match SHALL set; periodic=1: COUNT<=0; periodic=0: COUNT held, en<=0 (one-shot).
REQ-016 Resulting period SHALL be (COMPARE+1)*(PRESCALE+1) clk cycles.
REQ-017 Writing STATUS with data_i[0]=1 SHALL clear match (W1C); data_i[0]=0 no effect.
REQ-018 Simultaneous match-set and W1C in the same cycle: set SHALL win.
REQ-019 Bus write to COUNT in a tick cycle: write value SHALL win; no match evaluated that cycle.
REQ-020 Bus write to CTRL in a one-shot expiry cycle: written en SHALL win.
REQ-021 Write to PRESCALE or CTRL SHALL clear pre_cnt to 0.
REQ-022 we_i and rd_i both high SHALL perform the write; data_o shows pre-write value.

Reset
REQ-023 On rst=1, CTRL, PRESCALE, COUNT, STATUS, pre_cnt SHALL clear to 0 and COMPARE SHALL be 0xFFFF_FFFF, immediately, without clk.
REQ-024 irq_o SHALL be 0 during and after reset; reset mid-count SHALL discard all progress.

Configuration
REQ-025 Macro TIMER_PRESCALER_EN defined: prescaler per REQ-013/021.
REQ-026 TIMER_PRESCALER_EN undefined: no pre_cnt/PRESCALE storage, tick = en every cycle, PRESCALE reads 0, writes ignored, period = COMPARE+1.

Verification
REQ-027 PRESCALE=3, COMPARE=4, CTRL=0x3 -> match set exactly 20 cycles after CTRL write, repeats every 20 cycles, COUNT returns to 0.
REQ-028 COMPARE=2, PRESCALE=0, CTRL=0x5 (one-shot, ie) -> irq_o high after 3 cycles, en reads 0, COUNT holds 2; STATUS write 0x1 -> irq_o low next cycle.
REQ-029 W1C write to STATUS in same cycle as match -> match remains 1, irq_o stays 1.
REQ-030 COUNT=0xFFFF_FFFF, COMPARE=5, PRESCALE=0, en=1 -> COUNT wraps to 0 next cycle, no match.
REQ-031 Assert rst mid-count with no clk edge -> all registers reset values, irq_o=0 immediately.
REQ-032 Read offset 6 with rd_i=1 -> data_o=0; build without TIMER_PRESCALER_EN, COMPARE=4 -> period 5 cycles.
